// File: rtl/lut_interp_sched_if.sv
// lut_interp_sched_if: request/response and LUT configuration bundle for lut_interp_sched.
//   req/x_in    : per-requester request level and packed N-bit inputs
//   gnt/done    : one-hot owner of the lookup in flight / one-cycle result strobe
//   y_out/busy  : interpolated result, scheduler not idle
//   cfg_*       : LUT write port; a write lands only when cfg_we && cfg_ready
interface lut_interp_sched_if #(
  parameter int NREQ = 4,
  parameter int P    = 6,
  parameter int N    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] x_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [N-1:0]      y_out;
  logic              busy;
  logic              cfg_we;
  logic [P-1:0]      cfg_addr;
  logic [N-1:0]      cfg_data;
  logic              cfg_ready;

  modport master (
    output req, x_in, cfg_we, cfg_addr, cfg_data,
    input  gnt, done, y_out, busy, cfg_ready
  );

  modport slave (
    input  req, x_in, cfg_we, cfg_addr, cfg_data,
    output gnt, done, y_out, busy, cfg_ready
  );
endinterface

// File: rtl/lut_interp_sched.sv
// lut_interp_sched: round-robin scheduler sharing one single-port 2^P x N LUT
// between NREQ requesters. Each lookup reads LUT[x1] and LUT[x2] (x2 = x1+1,
// clamped at the top entry) and linearly interpolates with the 2-bit fraction.
// Fixed 5-cycle occupancy: IDLE(accept) -> RD1 -> RD2 -> CALC -> DONE -> IDLE.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (LUT contents are retained)
//   bus   : lut_interp_sched_if.slave (req/x_in/gnt/done/y_out/busy/cfg_*)
module lut_interp_sched #(
  parameter int NREQ = 4,
  parameter int P    = 6,
  parameter int N    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lut_interp_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, RD1, RD2, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     last_q;
  logic [N-1:0]      x_q, y1_q, y_q, rdata_q;
  logic [NREQ-1:0]   gnt_q, done_q;
  logic [N-1:0]      mem_q [2**P];

  logic [IW-1:0]     win_idx;
  logic              win_vld, accept;
  logic              lut_we;
  logic [P-1:0]      lut_addr, x1, x2;
  logic [1:0]        f;

  logic signed [N:0]   d;
  logic signed [N+2:0] d_x, f_x, p, sum;
  logic [N-1:0]        y_next;

  // Round robin: scan offsets NREQ..1 from last_q so the smallest offset
  // (closest after the last winner) is the final assignment.
  always_comb begin
    int            cc;
    logic [IW-1:0] c;
    win_vld = 1'b0;
    win_idx = '0;
    cc      = 0;
    c       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cc = int'(last_q) + k;
      if (cc >= NREQ) cc = cc - NREQ;
      c = IW'(cc);
      if (bus.req[c]) begin
        win_vld = 1'b1;
        win_idx = c;
      end
    end
  end

  // A config write in IDLE takes the LUT port, so the grant waits a cycle.
  assign accept = (state_q == IDLE) && !bus.cfg_we && win_vld;

  // Address split of the latched input; no wrap from the top entry to 0.
  assign x1 = x_q[N-1 -: P];
  assign f  = x_q[1:0];
  assign x2 = (x1 == {P{1'b1}}) ? x1 : x1 + 1'b1;

  // Interpolation in CALC: y2 sits on rdata_q, y1 was captured at the end of RD2.
  assign d      = $signed({1'b0, rdata_q}) - $signed({1'b0, y1_q});
  assign d_x    = {{2{d[N]}}, d};
  assign f_x    = {{(N+1){1'b0}}, f};
  assign p      = d_x * f_x;
  assign sum    = $signed({3'b000, y1_q}) + (p >>> 2);
  assign y_next = sum[N-1:0];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (LUT port steering)
  always_comb begin
    lut_we   = 1'b0;
    lut_addr = x1;
    unique case (state_q)
      IDLE: begin
        lut_we   = bus.cfg_we;
        lut_addr = bus.cfg_addr;
      end
      RD1:     lut_addr = x1;
      RD2:     lut_addr = x2;
      default: lut_addr = x1;
    endcase
  end

  // Single-port LUT, registered read; not reset.
  always_ff @(posedge clk) begin
    if (lut_we) mem_q[lut_addr] <= bus.cfg_data;
    rdata_q <= mem_q[lut_addr];
  end

  // Grant / capture / result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      done_q <= '0;
      y_q    <= '0;
      x_q    <= '0;
      y1_q   <= '0;
      last_q <= IW'(NREQ - 1);
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: if (accept) begin
          gnt_q  <= NREQ'(1) << win_idx;
          last_q <= win_idx;
          x_q    <= bus.x_in[N*win_idx +: N];
        end
        RD2:  y1_q <= rdata_q;
        CALC: begin
          y_q    <= y_next;
          done_q <= gnt_q;
        end
        DONE: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.y_out     = y_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cfg_ready = (state_q == IDLE);
endmodule

// File: tb/tb_lut_interp_sched.sv
module tb_lut_interp_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_interp_sched_if #(.NREQ(4), .P(6), .N(8)) bus ();

  lut_interp_sched #(.NREQ(4), .P(6), .N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int idx; int y;} exp_t;
  exp_t sb[$];
  int   ref_lut [64];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  // Reference interpolation with floor division done by hand.
  function automatic int ref_y(input int x);
    int x1, f, x2, y1, y2, pr, q;
    x1 = x / 4;
    f  = x % 4;
    x2 = (x1 == 63) ? 63 : x1 + 1;
    y1 = ref_lut[x1];
    y2 = ref_lut[x2];
    pr = f * (y2 - y1);
    q  = pr / 4;
    if (pr < 0 && (pr % 4) != 0) q = q - 1;
    return y1 + q;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input int a, input int v);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 6'(a);
    bus.cfg_data = 8'(v);
    ref_lut[a]   = v;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done !== 4'b0000) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    chk_cnt++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b exp 0000", bus.gnt); else pass_cnt++;
    chk_cnt++; if (bus.done !== 4'b0000) $display("FAIL reset_done: got %b exp 0000", bus.done); else pass_cnt++;
    chk_cnt++; if (bus.y_out !== 8'd0) $display("FAIL reset_y: got %0d exp 0", bus.y_out); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1)
      $display("FAIL reset_busy: busy=%b ready=%b exp 0/1", bus.busy, bus.cfg_ready); else pass_cnt++;
  endtask

  // Single requester-0 lookup with full timeline checks.
  task automatic test_basic(input int x, input string nm);
    exp_t e;
    int   lat;
    bus.x_in[7:0] = 8'(x);
    bus.req = 4'b0001;
    e = '{0, ref_y(x)};
    sb.push_back(e);
    @(negedge clk);
    chk_cnt++; if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1)
      $display("FAIL %s_gnt_e0: gnt=%b busy=%b exp 0001/1", nm, bus.gnt, bus.busy); else pass_cnt++;
    wait_done(lat);
    chk_cnt++; if (lat !== 3) $display("FAIL %s_latency: got %0d exp 3", nm, lat); else pass_cnt++;
    if (lat > 0) begin
      e = sb.pop_front();
      chk_cnt++; if (bus.done !== 4'(1 << e.idx)) $display("FAIL %s_done: got %b exp idx %0d", nm, bus.done, e.idx); else pass_cnt++;
      chk_cnt++; if (bus.y_out !== 8'(e.y)) $display("FAIL %s_y: got %0d exp %0d", nm, bus.y_out, e.y); else pass_cnt++;
      chk_cnt++; if (bus.gnt !== 4'b0001) $display("FAIL %s_gnt_done: got %b exp 0001", nm, bus.gnt); else pass_cnt++;
    end
    bus.req = 4'b0000;
    @(negedge clk);
    chk_cnt++; if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b0)
      $display("FAIL %s_idle: gnt=%b done=%b busy=%b exp 0000/0000/0", nm, bus.gnt, bus.done, bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.y_out !== 8'(ref_y(x))) $display("FAIL %s_yhold: got %0d exp %0d", nm, bus.y_out, ref_y(x)); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    exp_t e;
    int   lat;
    int   xs [4] = '{8'h25, 8'h2B, 8'hFF, 8'h81};
    int   order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) bus.x_in[8*i +: 8] = 8'(xs[i]);
    for (int i = 0; i < 5; i++) sb.push_back('{order[i], ref_y(xs[order[i]])});
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(lat);
      chk_cnt++; if (lat !== ((i == 0) ? 4 : 5))
        $display("FAIL rr_spacing%0d: got %0d exp %0d", i, lat, (i == 0) ? 4 : 5); else pass_cnt++;
      if (lat > 0) begin
        e = sb.pop_front();
        chk_cnt++; if (bus.done !== 4'(1 << e.idx)) $display("FAIL rr_done%0d: got %b exp idx %0d", i, bus.done, e.idx); else pass_cnt++;
        chk_cnt++; if (bus.y_out !== 8'(e.y)) $display("FAIL rr_y%0d: got %0d exp %0d", i, bus.y_out, e.y); else pass_cnt++;
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_cfg_collision;
    exp_t e;
    int   lat;
    cfg_write(10, 40);
    bus.cfg_we = 1'b1; bus.cfg_addr = 6'd9; bus.cfg_data = 8'd100; ref_lut[9] = 100;
    bus.x_in[7:0] = 8'h25; bus.req = 4'b0001;
    sb.push_back('{0, ref_y(8'h25)});
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk_cnt++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
      $display("FAIL coll_deferred: gnt=%b busy=%b exp 0000/0", bus.gnt, bus.busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.gnt !== 4'b0001) $display("FAIL coll_gnt: got %b exp 0001", bus.gnt); else pass_cnt++;
    // Write attempted while busy must be dropped.
    bus.cfg_we = 1'b1; bus.cfg_addr = 6'd9; bus.cfg_data = 8'd0;
    chk_cnt++; if (bus.cfg_ready !== 1'b0) $display("FAIL coll_ready: got %b exp 0", bus.cfg_ready); else pass_cnt++;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_done(lat);
    chk_cnt++; if (lat < 0) $display("FAIL coll_timeout: got no done exp done"); else pass_cnt++;
    if (lat > 0) begin
      e = sb.pop_front();
      chk_cnt++; if (bus.y_out !== 8'(e.y)) $display("FAIL coll_y: got %0d exp %0d", bus.y_out, e.y); else pass_cnt++;
    end
    bus.req = 4'b0000;
    @(negedge clk);
    test_basic(8'h24, "coll_keep");
  endtask

  task automatic test_reset_midflight;
    exp_t e;
    int   lat;
    bus.x_in[23:16] = 8'h81;
    bus.req = 4'b0100;
    @(negedge clk);
    chk_cnt++; if (bus.gnt !== 4'b0100) $display("FAIL mid_gnt2: got %b exp 0100", bus.gnt); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bus.x_in[15:8] = 8'h2B;
    bus.req = 4'b0110;
    @(negedge clk);
    chk_cnt++; if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.y_out !== 8'd0 || bus.busy !== 1'b0)
      $display("FAIL mid_reset: gnt=%b done=%b y=%0d busy=%b exp all 0", bus.gnt, bus.done, bus.y_out, bus.busy); else pass_cnt++;
    rst_n = 1'b1;
    sb.push_back('{1, ref_y(8'h2B)});
    @(negedge clk);
    chk_cnt++; if (bus.gnt !== 4'b0010) $display("FAIL mid_gnt1: got %b exp 0010", bus.gnt); else pass_cnt++;
    wait_done(lat);
    chk_cnt++; if (lat !== 3) $display("FAIL mid_latency: got %0d exp 3", lat); else pass_cnt++;
    if (lat > 0) begin
      e = sb.pop_front();
      chk_cnt++; if (bus.done !== 4'(1 << e.idx)) $display("FAIL mid_done: got %b exp idx %0d", bus.done, e.idx); else pass_cnt++;
      chk_cnt++; if (bus.y_out !== 8'(e.y)) $display("FAIL mid_y: got %0d exp %0d", bus.y_out, e.y); else pass_cnt++;
    end
    bus.req = 4'b0000;
    @(negedge clk);
    chk_cnt++; if (sb.size() !== 0) $display("FAIL sb_empty: got %0d entries exp 0", sb.size()); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.x_in = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    for (int k = 0; k < 64; k++) ref_lut[k] = 0;
    @(negedge clk);
    test_reset();
    for (int k = 0; k < 64; k++) cfg_write(k, 4 * k);
    test_basic(8'h25, "basic");
    cfg_write(10, 200);
    cfg_write(11, 100);
    test_basic(8'h2B, "neg_slope");
    cfg_write(63, 250);
    cfg_write(0, 0);
    test_basic(8'hFF, "clamp");
    test_round_robin();
    test_cfg_collision();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/lut_interp_sched.md
# lut_interp_sched

Time-shared scheduler for the 64-entry (P=6) LUT linear-interpolation datapath. It arbitrates up to NREQ requesters round-robin onto one single-port 64x8 LUT, owns that LUT, and runs each lookup as a fixed-latency two-read interpolation. It also provides the configuration write port that loads the table. It sits between the function-approximation clients and the LUT storage, replacing per-client combinational copies of the table.

## Interface
- NREQ, 4, number of requesters (2..8)
- P, 6, LUT address width; the LUT has 2^P entries
- N, 8, input and output data width; N-P = 2 fractional bits
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request level; must hold req[i] and x_in slice i stable until done[i]
- x_in  in  NREQ*N  packed inputs; requester i uses [N*i+N-1 : N*i]
- gnt  out  NREQ  one-hot owner of the lookup in flight; registered; 0 when idle
- done  out  NREQ  one-hot, single-cycle pulse marking y_out valid for that requester
- y_out  out  N  interpolated result; registered; holds its value until the next done
- busy  out  1  high whenever state is not IDLE
- cfg_we  in  1  LUT write strobe
- cfg_addr  in  P  LUT write address
- cfg_data  in  N  LUT write data
- cfg_ready  out  1  combinational; equals (state == IDLE); a write occurs only when cfg_we && cfg_ready

## Operation
- The LUT is internal 2^P x N memory: single port, synchronous read with 1-cycle registered data. It is not cleared by reset and its power-up contents are undefined.
- FSM states and transitions:
  - IDLE: if cfg_we, write LUT[cfg_addr] = cfg_data, issue no grant, stay in IDLE. Otherwise, if any req is set, grant the round-robin winner, latch its x, and go to RD1.
  - RD1 → RD2 → CALC → DONE → IDLE, unconditionally.
- Round robin: search starts at last_granted+1 and wraps modulo NREQ. After reset last_granted = NREQ-1, so requester 0 has priority first. last_granted updates on grant.
- Address split for the latched x:
  - x1 = x[N-1:N-P]
  - f = x[1:0]
  - x2 = x1+1, clamped: if x1 = 2^P-1 then x2 = x1. There is no wrap to entry 0.
- Reads: RD1 presents address x1; RD2 presents x2. y1 is captured at the end of RD2; y2 is on the read data port during CALC.
- Arithmetic in CALC:
  - d = y2 - y1 as a signed N+1-bit value.
  - p = f*d as a signed N+3-bit value.
  - y = y1 + (p >>> 2), an arithmetic shift, i.e. floor.
  - The result always lies between y1 and y2 and needs no saturation; it is truncated to N bits.
- Exit from CALC registers y_out, asserts done[owner] for the DONE cycle only, and holds gnt[owner] through DONE.
- gnt is cleared on return to IDLE.
- A req dropped before done is ignored: the lookup completes and done still pulses.
- A cfg_we with cfg_ready = 0 is dropped silently; the LUT is unchanged.

## Timing
- E0 is the accept edge, in IDLE with req set and cfg_we low. Timeline:
  - E1: RD2 entered.
  - E2: CALC entered.
  - E3: DONE entered, y_out and done valid.
  - E4: IDLE entered.
- Earliest next accept is E5. Sustained throughput is one lookup per 5 cycles.
- A requester that clears req on the edge where it samples done=1 is not re-granted.
- A cfg write at edge Ew is visible to any lookup accepted at or after Ew+1.
- When cfg_we and req are both present in IDLE, the write wins and the grant is deferred by one cycle.
- Reset (rst_n = 0 at an edge) applies in any state. Afterwards:
  - state = IDLE, gnt = 0, done = 0, y_out = 0, busy = 0, last_granted = NREQ-1.
  - Any in-flight lookup is dropped and produces no done.
  - LUT contents are retained.

## Test plan
- Preload LUT[k] = 4k via cfg, k = 0..63. req[0] with x = 0x25 (x1 = 9, f = 1) → y1 = 36, y2 = 40, y_out = 37, done[0] high in the cycle after E3, gnt = 0001 from E0 to E4.
- Set LUT[10] = 200 and LUT[11] = 100. x = 0x2B (f = 3) → d = -100, p = -300, y_out = 200 - 75 = 125.
- Clamp case: LUT[63] = 250 and LUT[0] = 0. x = 0xFF → y_out = 250, not 62.
- Hold all four req high with distinct x → grant order 0, 1, 2, 3, 0, with done pulses exactly 5 cycles apart and each y_out matching the reference model.
- Assert cfg_we (addr 9, data 100) and req[0] (x = 0x25) in the same IDLE cycle → write first, grant one cycle later, y_out = 100 + floor((40 - 100)/4) = 85. A cfg_we while busy leaves LUT[9] unchanged.
- Pull rst_n low during CALC of a req[2] lookup → no done[2]. The next cycle shows all outputs 0 and busy = 0. With req[1] and req[2] both held afterwards, requester 1 is granted first.
